// File: rtl/riscv_pkg.sv
// Shared encodings for the multicycle RISC-V control path: FSM states, opcodes, mux selects.
// The JALR states exist only when MCCTRL_JALR_EN is defined.
package riscv_pkg;

    typedef enum logic [3:0] {
        StFetch,
        StDecode,
        StMemAdr,
        StMemRead,
        StMemWb,
        StMemWrite,
        StExecR,
        StExecI,
        StAluWb,
        StJal,
        StBeq
`ifdef MCCTRL_JALR_EN
        ,
        StJalr,
        StJalrLink
`endif
    } state_e;

    localparam logic [6:0] OpLoad   = 7'b0000011;
    localparam logic [6:0] OpStore  = 7'b0100011;
    localparam logic [6:0] OpRType  = 7'b0110011;
    localparam logic [6:0] OpIAlu   = 7'b0010011;
    localparam logic [6:0] OpJal    = 7'b1101111;
    localparam logic [6:0] OpBranch = 7'b1100011;
    localparam logic [6:0] OpJalr   = 7'b1100111;

    localparam logic [1:0] AluOpAdd   = 2'b00;
    localparam logic [1:0] AluOpSub   = 2'b01;
    localparam logic [1:0] AluOpFunct = 2'b10;

    localparam logic [2:0] AluAdd = 3'b000;
    localparam logic [2:0] AluSub = 3'b001;
    localparam logic [2:0] AluAnd = 3'b010;
    localparam logic [2:0] AluOr  = 3'b011;
    localparam logic [2:0] AluSlt = 3'b101;

    localparam logic [1:0] ResAluOut    = 2'b00;
    localparam logic [1:0] ResData      = 2'b01;
    localparam logic [1:0] ResAluResult = 2'b10;

    localparam logic [1:0] SrcAPc    = 2'b00;
    localparam logic [1:0] SrcAOldPc = 2'b01;
    localparam logic [1:0] SrcARd1   = 2'b10;

    localparam logic [1:0] SrcBRd2   = 2'b00;
    localparam logic [1:0] SrcBImm   = 2'b01;
    localparam logic [1:0] SrcBFour  = 2'b10;

    localparam logic [1:0] ImmI = 2'b00;
    localparam logic [1:0] ImmS = 2'b01;
    localparam logic [1:0] ImmB = 2'b10;
    localparam logic [1:0] ImmJ = 2'b11;

endpackage

// File: rtl/mc_aludec.sv
// ALU decoder: maps ALUOp plus instruction fields to ALUControl.
// Shared between the single-cycle and multicycle controllers.
module mc_aludec
    import riscv_pkg::*;
(
    input  logic [1:0] alu_op_i,
    input  logic [2:0] funct3_i,
    input  logic       funct7b5_i,
    input  logic       op5_i,
    output logic [2:0] alu_control_o
);

    always_comb begin
        alu_control_o = AluAdd;
        unique case (alu_op_i)
            AluOpAdd: alu_control_o = AluAdd;
            AluOpSub: alu_control_o = AluSub;
            AluOpFunct: begin
                case (funct3_i)
                    // Only R-type sets op[5]; addi with imm[10]=1 must still add.
                    3'b000:  alu_control_o = (op5_i & funct7b5_i) ? AluSub : AluAdd;
                    3'b010:  alu_control_o = AluSlt;
                    3'b110:  alu_control_o = AluOr;
                    3'b111:  alu_control_o = AluAnd;
                    default: alu_control_o = AluAdd;
                endcase
            end
            default: alu_control_o = AluAdd;
        endcase
    end

endmodule

// File: rtl/mc_controller.sv
// Multicycle RISC-V control unit with a memory-ready handshake on the shared memory port.
// Define MCCTRL_JALR_EN to add jalr support (JALR -> JALRLINK -> ALUWB).
module mc_controller
    import riscv_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] op,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    input  logic       Zero,
    input  logic       MemReady,
    output logic       PCWrite,
    output logic       AdrSrc,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic [1:0] ResultSrc,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ImmSrc,
    output logic [2:0] ALUControl,
    output logic       RegWrite,
    output logic       Illegal
);

    state_e     state_q, state_d;
    logic       pc_update, branch, mem_write, ir_write, reg_write, illegal;
    logic [1:0] alu_op;

    always_ff @(posedge clk) begin
        if (!reset) state_q <= StFetch;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d   = state_q;
        pc_update = 1'b0;
        branch    = 1'b0;
        mem_write = 1'b0;
        ir_write  = 1'b0;
        reg_write = 1'b0;
        illegal   = 1'b0;
        AdrSrc    = 1'b0;
        ResultSrc = ResAluOut;
        ALUSrcA   = SrcAPc;
        ALUSrcB   = SrcBRd2;
        alu_op    = AluOpAdd;
        case (state_q)
            StFetch: begin
                ALUSrcB   = SrcBFour;
                ResultSrc = ResAluResult;
                ir_write  = MemReady;
                pc_update = MemReady;
                if (MemReady) state_d = StDecode;
            end
            StDecode: begin
                ALUSrcA = SrcAOldPc;
                ALUSrcB = SrcBImm;
                case (op)
                    OpLoad, OpStore: state_d = StMemAdr;
                    OpRType:         state_d = StExecR;
                    OpIAlu:          state_d = StExecI;
                    OpJal:           state_d = StJal;
                    OpBranch:        state_d = StBeq;
`ifdef MCCTRL_JALR_EN
                    OpJalr:          state_d = StJalr;
`endif
                    default: begin
                        state_d = StFetch;
                        illegal = 1'b1;
                    end
                endcase
            end
            StMemAdr: begin
                ALUSrcA = SrcARd1;
                ALUSrcB = SrcBImm;
                state_d = (op == OpLoad) ? StMemRead : StMemWrite;
            end
            StMemRead: begin
                AdrSrc = 1'b1;
                if (MemReady) state_d = StMemWb;
            end
            StMemWb: begin
                ResultSrc = ResData;
                reg_write = 1'b1;
                state_d   = StFetch;
            end
            StMemWrite: begin
                AdrSrc    = 1'b1;
                mem_write = 1'b1;
                if (MemReady) state_d = StFetch;
            end
            StExecR: begin
                ALUSrcA = SrcARd1;
                alu_op  = AluOpFunct;
                state_d = StAluWb;
            end
            StExecI: begin
                ALUSrcA = SrcARd1;
                ALUSrcB = SrcBImm;
                alu_op  = AluOpFunct;
                state_d = StAluWb;
            end
            StAluWb: begin
                reg_write = 1'b1;
                state_d   = StFetch;
            end
            StJal: begin
                ALUSrcA   = SrcAOldPc;
                ALUSrcB   = SrcBFour;
                pc_update = 1'b1;
                state_d   = StAluWb;
            end
            StBeq: begin
                ALUSrcA = SrcARd1;
                alu_op  = AluOpSub;
                branch  = 1'b1;
                state_d = StFetch;
            end
`ifdef MCCTRL_JALR_EN
            StJalr: begin
                ALUSrcA   = SrcARd1;
                ALUSrcB   = SrcBImm;
                ResultSrc = ResAluResult;
                pc_update = 1'b1;
                state_d   = StJalrLink;
            end
            StJalrLink: begin
                ALUSrcA = SrcAOldPc;
                ALUSrcB = SrcBFour;
                state_d = StAluWb;
            end
`endif
            default: state_d = StFetch;
        endcase
    end

    always_comb begin
        case (op)
            OpStore:  ImmSrc = ImmS;
            OpBranch: ImmSrc = ImmB;
            OpJal:    ImmSrc = ImmJ;
            default:  ImmSrc = ImmI;
        endcase
    end

    // Strobes are gated by reset so an abandoned instruction cannot commit anything.
    assign PCWrite  = reset & (pc_update | (branch & (Zero ^ funct3[0])));
    assign IRWrite  = reset & ir_write;
    assign MemWrite = reset & mem_write;
    assign RegWrite = reset & reg_write;
    assign Illegal  = reset & illegal;

    mc_aludec u_aludec (
        .alu_op_i      (alu_op),
        .funct3_i      (funct3),
        .funct7b5_i    (funct7b5),
        .op5_i         (op[5]),
        .alu_control_o (ALUControl)
    );

endmodule

// File: tb/tb_mc_controller.sv
// Directed self-checking bench for mc_controller; each task starts and ends in FETCH.
// Honours MCCTRL_JALR_EN for the jalr/illegal scenario.
module tb_mc_controller;

    logic       clk = 1'b0;
    logic       reset;
    logic [6:0] op;
    logic [2:0] funct3;
    logic       funct7b5, Zero, MemReady;
    logic       PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, Illegal;
    logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, ImmSrc;
    logic [2:0] ALUControl;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mc_controller dut (
        .clk        (clk),
        .reset      (reset),
        .op         (op),
        .funct3     (funct3),
        .funct7b5   (funct7b5),
        .Zero       (Zero),
        .MemReady   (MemReady),
        .PCWrite    (PCWrite),
        .AdrSrc     (AdrSrc),
        .MemWrite   (MemWrite),
        .IRWrite    (IRWrite),
        .ResultSrc  (ResultSrc),
        .ALUSrcA    (ALUSrcA),
        .ALUSrcB    (ALUSrcB),
        .ImmSrc     (ImmSrc),
        .ALUControl (ALUControl),
        .RegWrite   (RegWrite),
        .Illegal    (Illegal)
    );

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic test_reset();
        reset = 1'b0; MemReady = 1'b1; Zero = 1'b0;
        op = 7'b0110011; funct3 = 3'b000; funct7b5 = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if ({PCWrite, IRWrite, MemWrite, RegWrite, Illegal} !== 5'b0) begin
                errors++;
                $display("FAIL reset_strobes cyc%0d: got %b want 00000", i,
                         {PCWrite, IRWrite, MemWrite, RegWrite, Illegal});
            end
        end
        reset = 1'b1;
        #1;
        checks++;
        if ({IRWrite, PCWrite, AdrSrc, ALUSrcB, ResultSrc} !== 7'b1101010) begin
            errors++;
            $display("FAIL reset_first_fetch: got %b want 1101010",
                     {IRWrite, PCWrite, AdrSrc, ALUSrcB, ResultSrc});
        end
    endtask

    task automatic test_lw();
        logic [31:0] instr = 32'hFFC4A303;
        op = instr[6:0]; funct3 = instr[14:12]; funct7b5 = instr[30];
        checks++;
        if ({IRWrite, RegWrite} !== 2'b10) begin
            errors++; $display("FAIL lw_c1: got %b want 10", {IRWrite, RegWrite});
        end
        step();
        checks++;
        if ({ALUSrcA, ALUSrcB, ImmSrc, Illegal, RegWrite} !== 8'b01010000) begin
            errors++;
            $display("FAIL lw_c2_decode: got %b want 01010000",
                     {ALUSrcA, ALUSrcB, ImmSrc, Illegal, RegWrite});
        end
        step();
        checks++;
        if ({ALUSrcA, ALUSrcB, ALUControl, RegWrite} !== 8'b10010000) begin
            errors++;
            $display("FAIL lw_c3_memadr: got %b want 10010000",
                     {ALUSrcA, ALUSrcB, ALUControl, RegWrite});
        end
        step();
        checks++;
        if ({AdrSrc, ResultSrc, RegWrite, MemWrite} !== 5'b10000) begin
            errors++;
            $display("FAIL lw_c4_memread: got %b want 10000",
                     {AdrSrc, ResultSrc, RegWrite, MemWrite});
        end
        step();
        checks++;
        if ({RegWrite, ResultSrc} !== 3'b101) begin
            errors++; $display("FAIL lw_c5_memwb: got %b want 101", {RegWrite, ResultSrc});
        end
        step();
        checks++;
        if ({IRWrite, RegWrite} !== 2'b10) begin
            errors++; $display("FAIL lw_back_fetch: got %b want 10", {IRWrite, RegWrite});
        end
    endtask

    task automatic test_sw_stall();
        op = 7'b0100011; funct3 = 3'b010; funct7b5 = 1'b0;
        MemReady = 1'b0;
        #1;
        checks++;
        if ({IRWrite, PCWrite} !== 2'b00) begin
            errors++; $display("FAIL fetch_stall_strobes: got %b want 00", {IRWrite, PCWrite});
        end
        step();
        checks++;
        if ({ALUSrcB, ResultSrc, IRWrite} !== 5'b10100) begin
            errors++;
            $display("FAIL fetch_stall_hold: got %b want 10100", {ALUSrcB, ResultSrc, IRWrite});
        end
        MemReady = 1'b1;
        step();
        checks++;
        if (ImmSrc !== 2'b01) begin
            errors++; $display("FAIL sw_immsrc: got %b want 01", ImmSrc);
        end
        MemReady = 1'b0;
        step();
        step();
        for (int i = 0; i < 3; i++) begin
            if (i == 2) begin
                MemReady = 1'b1;
                #1;
            end
            checks++;
            if ({MemWrite, AdrSrc, RegWrite} !== 3'b110) begin
                errors++;
                $display("FAIL sw_memwrite_cyc%0d: got %b want 110", i,
                         {MemWrite, AdrSrc, RegWrite});
            end
            if (i < 2) step();
        end
        step();
        checks++;
        if ({MemWrite, IRWrite} !== 2'b01) begin
            errors++; $display("FAIL sw_back_fetch: got %b want 01", {MemWrite, IRWrite});
        end
    endtask

    task automatic test_branch(input logic [2:0] f3, input logic z, input logic exp_pcw);
        op = 7'b1100011; funct3 = f3; funct7b5 = 1'b0; Zero = 1'b0;
        step();
        checks++;
        if ({ImmSrc, PCWrite} !== 3'b100) begin
            errors++; $display("FAIL br_decode: got %b want 100", {ImmSrc, PCWrite});
        end
        Zero = z;
        step();
        checks++;
        if ({PCWrite, ALUControl, ALUSrcA, ALUSrcB} !== {exp_pcw, 7'b0011000}) begin
            errors++;
            $display("FAIL br_f3%b_z%b: got %b want %b", f3, z,
                     {PCWrite, ALUControl, ALUSrcA, ALUSrcB}, {exp_pcw, 7'b0011000});
        end
        Zero = 1'b0;
        step();
        checks++;
        if (IRWrite !== 1'b1) begin
            errors++; $display("FAIL br_back_fetch: got %b want 1", IRWrite);
        end
    endtask

    task automatic test_alu(input logic [6:0] opc, input logic [2:0] f3, input logic f7,
                            input logic [2:0] exp_ctl);
        op = opc; funct3 = f3; funct7b5 = f7;
        step();
        step();
        checks++;
        if ({ALUControl, ALUSrcA, ALUSrcB[1], RegWrite}
            !== {exp_ctl, 2'b10, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL alu_op%b_f3%b: got %b want %b", opc, f3,
                     {ALUControl, ALUSrcA, ALUSrcB[1], RegWrite}, {exp_ctl, 4'b1000});
        end
        checks++;
        if (ALUSrcB[0] !== opc[5] ^ 1'b1) begin
            errors++; $display("FAIL alu_srcb_op%b: got %b want %b", opc, ALUSrcB[0], ~opc[5]);
        end
        step();
        checks++;
        if ({RegWrite, ResultSrc} !== 3'b100) begin
            errors++; $display("FAIL alu_wb: got %b want 100", {RegWrite, ResultSrc});
        end
        step();
        checks++;
        if (IRWrite !== 1'b1) begin
            errors++; $display("FAIL alu_back_fetch: got %b want 1", IRWrite);
        end
    endtask

    task automatic test_jal();
        op = 7'b1101111; funct3 = 3'b000; funct7b5 = 1'b0;
        step();
        checks++;
        if (ImmSrc !== 2'b11) begin
            errors++; $display("FAIL jal_immsrc: got %b want 11", ImmSrc);
        end
        step();
        checks++;
        if ({PCWrite, ALUSrcA, ALUSrcB, RegWrite} !== 6'b101100) begin
            errors++;
            $display("FAIL jal_state: got %b want 101100", {PCWrite, ALUSrcA, ALUSrcB, RegWrite});
        end
        step();
        checks++;
        if ({RegWrite, PCWrite} !== 2'b10) begin
            errors++; $display("FAIL jal_wb: got %b want 10", {RegWrite, PCWrite});
        end
        step();
        checks++;
        if (IRWrite !== 1'b1) begin
            errors++; $display("FAIL jal_back_fetch: got %b want 1", IRWrite);
        end
    endtask

    task automatic test_jalr_or_illegal();
        op = 7'b1100111; funct3 = 3'b000; funct7b5 = 1'b0;
        step();
`ifdef MCCTRL_JALR_EN
        checks++;
        if (Illegal !== 1'b0) begin
            errors++; $display("FAIL jalr_no_illegal: got %b want 0", Illegal);
        end
        step();
        checks++;
        if ({PCWrite, ALUSrcA, ALUSrcB, ResultSrc} !== 7'b1100110) begin
            errors++;
            $display("FAIL jalr_state: got %b want 1100110",
                     {PCWrite, ALUSrcA, ALUSrcB, ResultSrc});
        end
        step();
        checks++;
        if ({PCWrite, ALUSrcA, ALUSrcB, RegWrite} !== 6'b001100) begin
            errors++;
            $display("FAIL jalrlink_state: got %b want 001100",
                     {PCWrite, ALUSrcA, ALUSrcB, RegWrite});
        end
        step();
        checks++;
        if (RegWrite !== 1'b1) begin
            errors++; $display("FAIL jalr_c5_wb: got %b want 1", RegWrite);
        end
        step();
`else
        checks++;
        if (Illegal !== 1'b1) begin
            errors++; $display("FAIL illegal_pulse: got %b want 1", Illegal);
        end
        step();
`endif
        checks++;
        if ({IRWrite, Illegal, RegWrite} !== 3'b100) begin
            errors++;
            $display("FAIL jalr_back_fetch: got %b want 100", {IRWrite, Illegal, RegWrite});
        end
    endtask

    task automatic test_mid_reset();
        op = 7'b0000011; funct3 = 3'b010; funct7b5 = 1'b0;
        step();
        step();
        step();
        step();
        reset = 1'b0;
        #1;
        checks++;
        if ({RegWrite, PCWrite, IRWrite} !== 3'b000) begin
            errors++;
            $display("FAIL midreset_no_write: got %b want 000", {RegWrite, PCWrite, IRWrite});
        end
        step();
        reset = 1'b1;
        #1;
        checks++;
        if ({IRWrite, PCWrite, RegWrite} !== 3'b110) begin
            errors++;
            $display("FAIL midreset_fetch: got %b want 110", {IRWrite, PCWrite, RegWrite});
        end
    endtask

    initial begin
        test_reset();
        test_lw();
        test_sw_stall();
        test_branch(3'b000, 1'b1, 1'b1);
        test_branch(3'b000, 1'b0, 1'b0);
        test_branch(3'b001, 1'b0, 1'b1);
        test_branch(3'b001, 1'b1, 1'b0);
        test_alu(7'b0110011, 3'b000, 1'b1, 3'b001);
        test_alu(7'b0010011, 3'b000, 1'b1, 3'b000);
        test_alu(7'b0110011, 3'b010, 1'b0, 3'b101);
        test_alu(7'b0110011, 3'b110, 1'b0, 3'b011);
        test_alu(7'b0010011, 3'b111, 1'b0, 3'b010);
        test_alu(7'b0110011, 3'b100, 1'b0, 3'b000);
        test_jal();
        test_jalr_or_illegal();
        test_mid_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
